// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: debounced buttons drive four LEDs, either as a prescaled
// Johnson scroll or as per-LED manual toggles selected by a mode button.
module led_mode_sequencer #(
    parameter int DIV_WIDTH  = 19,
    parameter int DEB_CYCLES = 16500,
    parameter int DEB_WIDTH  = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BTN,
    input  logic       MODE_BTN,
    output logic [3:0] LED,
    output logic       MODE,
    output logic       TICK
);
    typedef enum logic {SCROLL = 1'b0, MANUAL = 1'b1} state_e;
    localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_CYCLES - 1);

    state_e               state_q, state_d;
    logic [4:0]           sync1_q, sync2_q, stable_q, stable_d, prev_q, press_q;
    logic [DEB_WIDTH-1:0] cnt_q [5];
    logic [DEB_WIDTH-1:0] cnt_d [5];
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [5:0]           rot_q, rot_d;
    logic [3:0]           man_q, man_d, led_q;
    logic                 tick;

    assign tick = (state_q == SCROLL) && (&div_q);
    assign TICK = tick;
    assign MODE = state_q;
    assign LED  = led_q;

    // Bit 4 carries the mode button through the same synchronize/debounce path.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i] + DEB_WIDTH'(1);
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
            end
        end
    end

    // A mode press wins over a same-cycle tick or LED press.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        man_d   = man_q;
        div_d   = '0;
        if (state_q == SCROLL) begin
            div_d = div_q + DIV_WIDTH'(1);
            if (press_q[4]) begin
                state_d = MANUAL;
                man_d   = rot_q[3:0];
                div_d   = '0;
            end else if (tick) begin
                rot_d = {rot_q[4:0], ~rot_q[5]};
            end
        end else begin
            if (press_q[4]) begin
                state_d = SCROLL;
                rot_d   = '0;
            end else begin
                man_d = man_q ^ press_q[3:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= SCROLL;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            press_q  <= '0;
            div_q    <= '0;
            rot_q    <= '0;
            man_q    <= '0;
            led_q    <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= {MODE_BTN, BTN};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            press_q  <= stable_q & ~prev_q;
            div_q    <= div_d;
            rot_q    <= rot_d;
            man_q    <= man_d;
            led_q    <= (state_d == MANUAL) ? man_d : rot_d[3:0];
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: scoreboard bench; a cycle-level reference model pushes
// expected LED/MODE/TICK per clock and a monitor pops and compares them.
module tb_led_mode_sequencer;
    localparam int DIV_WIDTH = 3;
    localparam int DEB = 4;
    localparam int PER = 1 << DIV_WIDTH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] raw = '0;
    logic [3:0] led;
    logic       mode, tick;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [5:0] exp_q [$];
    logic [3:0] pat [12] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF,
                             4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};

    led_mode_sequencer #(.DIV_WIDTH(DIV_WIDTH), .DEB_CYCLES(DEB), .DEB_WIDTH(2)) dut (
        .CLK(clk), .RST(rst), .BTN(raw[3:0]), .MODE_BTN(raw[4]),
        .LED(led), .MODE(mode), .TICK(tick)
    );

    always #5 clk = ~clk;

    // Reference model: sync = 2-clock delay, debounce = last DEB synced samples
    // all disagree with stable, press = stable rise seen two clocks later,
    // scroll position = index into the 12-step LED pattern.
    logic [4:0]     m_s1 = '0, m_s2 = '0, m_st = '0, r1 = '0, r2 = '0;
    logic [DEB-1:0] win [5];
    logic           m_mode = 1'b0;
    logic [3:0]     m_man = '0;
    int             m_pos = 0;
    int             m_ph = 0;

    initial begin
        logic [4:0] syn, rise, pev;
        logic       t;
        foreach (win[i]) win[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_st = '0; r1 = '0; r2 = '0;
                foreach (win[i]) win[i] = '0;
                m_mode = 1'b0; m_man = '0; m_pos = 0; m_ph = 0;
            end else begin
                pev = r2;
                r2 = r1;
                syn = m_s2;
                m_s2 = m_s1;
                m_s1 = raw;
                rise = '0;
                for (int i = 0; i < 5; i++) begin
                    win[i] = {win[i][DEB-2:0], syn[i]};
                    if (win[i] == {DEB{~m_st[i]}}) begin
                        m_st[i] = ~m_st[i];
                        rise[i] = m_st[i];
                    end
                end
                r1 = rise;
                t = !m_mode && (m_ph == PER - 1);
                if (!m_mode) begin
                    if (pev[4]) begin
                        m_mode = 1'b1; m_man = pat[m_pos]; m_ph = 0;
                    end else begin
                        if (t) m_pos = (m_pos + 1) % 12;
                        m_ph = (m_ph + 1) % PER;
                    end
                end else if (pev[4]) begin
                    m_mode = 1'b0; m_pos = 0; m_ph = 0;
                end else begin
                    m_man = m_man ^ pev[3:0];
                end
            end
            exp_q.push_back({m_mode ? m_man : pat[m_pos], m_mode, !m_mode && (m_ph == PER - 1)});
        end
    end

    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({led, mode, tick} !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got led=%h mode=%b tick=%b, want led=%h mode=%b tick=%b",
                             cyc, led, mode, tick, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_btn(input logic [4:0] m, input int hold);
        raw = raw | m;
        cycles(hold);
        raw = raw & ~m;
        cycles(DEB + 8);
    endtask

    task automatic wait_model(input logic want_mode, input int pos, input int ph);
        int n = 0;
        while (!(m_mode == want_mode && m_pos == pos && m_ph == ph) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_model: timed out after %0d clocks waiting for mode=%b pos=%0d phase=%0d",
                     n, want_mode, pos, ph);
        end
    endtask

    initial begin
        cycles(2);
        rst = 1'b0;
        cycles(100);
        raw = 5'h04; cycles(3); raw = '0; cycles(10);
        raw = 5'h10; cycles(3); raw = '0; cycles(10);
        foreach (pat[i]) if (i < 5) begin raw[4] = (i != 1 && i != 4); cycles(1); end
        raw[4] = 1'b1; cycles(10); raw[4] = 1'b0; cycles(12);
        push_btn(5'h10, 6);
        wait_model(1'b0, 2, 1);
        push_btn(5'h10, 6);
        cycles(200);
        push_btn(5'h08, 6);
        push_btn(5'h01, 6);
        push_btn(5'h01, 50);
        push_btn(5'h10, 6);
        cycles(30);
        push_btn(5'h10, 6);
        push_btn(5'h12, 6);
        wait_model(1'b0, 2, 0);
        push_btn(5'h10, 6);
        push_btn(5'h08, 6);
        raw = 5'h11; cycles(3);
        rst = 1'b1; cycles(1); rst = 1'b0;
        cycles(20); raw = '0; cycles(12);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1; cycles(1); rst = 1'b0;
            end
            raw = 5'($urandom_range(0, 31));
            cycles($urandom_range(1, 12));
        end
        raw = '0;
        cycles(3);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
